// File: rtl/uart_core.sv
// uart_core: full-duplex UART with one RX engine and one TX engine.
// Data width, parity, stop bits and baud divisor are set by parameters.
// Both sides use valid/ready byte streams. CTS/RTS flow control is optional.
module uart_core #(
  parameter int CLK_HZ      = 12_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 3,
  parameter int FLOW_CTRL   = 1
) (
  input  logic                 ice_clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic                 cts_n,
  output logic                 rts_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(DIV / 2 - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  if (DIV < 8) begin : g_div_check
    $error("uart_core: CLK_HZ/BAUD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
    $error("uart_core: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_check
    $error("uart_core: PARITY must be 0, 1 or 2");
  end
  if (SYNC_STAGES < 2) begin : g_sync_check
    $error("uart_core: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Parity bit that makes the frame odd (PARITY=1) or even (PARITY=2).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [SYNC_STAGES-1:0] rxd_sync;
  logic [SYNC_STAGES-1:0] cts_chain;
  logic                   rx_line;
  logic                   cts_sync;

  // Input synchronisers; both lines reset to the idle (high) level.
  always_ff @(posedge ice_clk) begin
    if (rst) begin
      rxd_sync  <= '1;
      cts_chain <= '1;
    end else begin
      rxd_sync  <= {rxd_sync[SYNC_STAGES-2:0], rxd};
      cts_chain <= {cts_chain[SYNC_STAGES-2:0], cts_n};
    end
  end

  assign rx_line  = rxd_sync[SYNC_STAGES-1];
  assign cts_sync = cts_chain[SYNC_STAGES-1];

  // ---------------- transmitter ----------------
  state_t                 tx_state, tx_state_nxt;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
  logic [3:0]             tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_nxt;
  logic                   tx_par, tx_par_nxt;
  logic                   tx_line_nxt;
  logic                   txd_q;

  assign tx_ready = (tx_state == ST_IDLE) & ~rst & (~cts_sync | (FLOW_CTRL == 0));
  assign txd      = txd_q;

  // TX state register; the line output is registered so txd never glitches.
  always_ff @(posedge ice_clk) begin
    tx_shift <= tx_shift_nxt;
    tx_par   <= tx_par_nxt;
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      txd_q    <= tx_line_nxt;
    end
  end

  // TX next-state: each non-idle state holds its bit for DIV cycles.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_line_nxt  = 1'b1;
    case (tx_state)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          tx_shift_nxt = tx_data;
          tx_par_nxt   = parity_bit(tx_data);
          tx_cnt_nxt   = '0;
          tx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = ST_DATA;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = tx_shift >> 1;
          if (tx_bit == DATA_LAST) begin
            tx_bit_nxt   = '0;
            tx_state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            tx_bit_nxt = tx_bit + 1'b1;
          end
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = ST_STOP;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_nxt = '0;
          if (tx_bit == STOP_LAST) begin
            tx_bit_nxt   = '0;
            tx_state_nxt = ST_IDLE;
          end else begin
            tx_bit_nxt = tx_bit + 1'b1;
          end
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = ST_IDLE;
    endcase
    case (tx_state_nxt)
      ST_START:  tx_line_nxt = 1'b0;
      ST_DATA:   tx_line_nxt = tx_shift_nxt[0];
      ST_PARITY: tx_line_nxt = tx_par_nxt;
      default:   tx_line_nxt = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  state_t                 rx_state, rx_state_nxt;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
  logic [3:0]             rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_nxt;
  logic                   rx_perr, rx_perr_nxt;
  logic                   rx_ferr, rx_ferr_nxt;
  logic                   rx_prev;
  logic                   rx_done;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;

  // RX state register plus the previous line level for start-edge detection.
  always_ff @(posedge ice_clk) begin
    rx_shift <= rx_shift_nxt;
    if (rst) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_prev  <= 1'b1;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_perr  <= rx_perr_nxt;
      rx_ferr  <= rx_ferr_nxt;
      rx_prev  <= rx_line;
    end
  end

  // RX next-state: first sample at DIV/2, then every DIV cycles at mid-bit.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_perr_nxt  = rx_perr;
    rx_ferr_nxt  = rx_ferr;
    rx_done      = 1'b0;
    case (rx_state)
      ST_IDLE: begin
        if (rx_prev && !rx_line) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_nxt = '0;
          if (rx_line) begin
            rx_state_nxt = ST_IDLE;
          end else begin
            rx_bit_nxt   = '0;
            rx_perr_nxt  = 1'b0;
            rx_ferr_nxt  = 1'b0;
            rx_state_nxt = ST_DATA;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_line, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == DATA_LAST) begin
            rx_bit_nxt   = '0;
            rx_state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            rx_bit_nxt = rx_bit + 1'b1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_nxt   = '0;
          rx_bit_nxt   = '0;
          rx_perr_nxt  = (parity_bit(rx_shift) != rx_line);
          rx_state_nxt = ST_STOP;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_nxt  = '0;
          rx_ferr_nxt = rx_ferr | ~rx_line;
          if (rx_bit == STOP_LAST) begin
            rx_bit_nxt   = '0;
            rx_done      = 1'b1;
            rx_state_nxt = ST_IDLE;
          end else begin
            rx_bit_nxt = rx_bit + 1'b1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = ST_IDLE;
    endcase
  end

  // RX output holding register: a full register discards new frames as overrun.
  always_ff @(posedge ice_clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= rx_shift;
          rx_perr_q  <= rx_perr;
          rx_ferr_q  <= rx_ferr_nxt;
          rx_valid_q <= 1'b1;
        end else begin
          rx_ovr_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rts_n         = (FLOW_CTRL != 0) ? rx_valid_q : 1'b0;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: three instances (8N1 @ DIV=104, 7E2 loopback @ DIV=8,
// 8O1 @ DIV=16). Received bytes are checked by scoreboard monitors.
module tb_uart_core;
  logic ice_clk;
  logic rst_a, rst_bc;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t ea, eb, ec;
  int   ovr_a = 0, ovr_b = 0, ovr_c = 0;

  // instance A: 8N1, DIV = 104
  logic       rxd_a, txd_a, cts_n_a, rts_n_a, tx_valid_a, tx_ready_a;
  logic       rx_valid_a, rx_ready_a, pe_a, fe_a, rx_overrun_a;
  logic [7:0] tx_data_a, rx_data_a;

  // instance B: 7 data, even parity, 2 stop, DIV = 8, txd looped to rxd
  logic       txd_b, rts_n_b, tx_valid_b, tx_ready_b, cts_n_b;
  logic       rx_valid_b, rx_ready_b, pe_b, fe_b, rx_overrun_b;
  logic [6:0] tx_data_b, rx_data_b;

  // instance C: 8 data, odd parity, 1 stop, DIV = 16
  logic       rxd_c, txd_c, cts_n_c, rts_n_c, tx_valid_c, tx_ready_c;
  logic       rx_valid_c, rx_ready_c, pe_c, fe_c, rx_overrun_c;
  logic [7:0] tx_data_c, rx_data_c;

  uart_core #(.CLK_HZ(12_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
              .STOP_BITS(1), .SYNC_STAGES(3), .FLOW_CTRL(1)) u_a (
    .ice_clk(ice_clk), .rst(rst_a), .rxd(rxd_a), .txd(txd_a),
    .cts_n(cts_n_a), .rts_n(rts_n_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .rx_parity_err(pe_a),
    .rx_frame_err(fe_a), .rx_overrun(rx_overrun_a));

  uart_core #(.CLK_HZ(12_000_000), .BAUD(1_500_000), .DATA_BITS(7), .PARITY(2),
              .STOP_BITS(2), .SYNC_STAGES(3), .FLOW_CTRL(1)) u_b (
    .ice_clk(ice_clk), .rst(rst_bc), .rxd(txd_b), .txd(txd_b),
    .cts_n(cts_n_b), .rts_n(rts_n_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .rx_parity_err(pe_b),
    .rx_frame_err(fe_b), .rx_overrun(rx_overrun_b));

  uart_core #(.CLK_HZ(12_000_000), .BAUD(750_000), .DATA_BITS(8), .PARITY(1),
              .STOP_BITS(1), .SYNC_STAGES(3), .FLOW_CTRL(1)) u_c (
    .ice_clk(ice_clk), .rst(rst_bc), .rxd(rxd_c), .txd(txd_c),
    .cts_n(cts_n_c), .rts_n(rts_n_c), .tx_data(tx_data_c),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .rx_data(rx_data_c),
    .rx_valid(rx_valid_c), .rx_ready(rx_ready_c), .rx_parity_err(pe_c),
    .rx_frame_err(fe_c), .rx_overrun(rx_overrun_c));

  initial ice_clk = 1'b0;
  always #5 ice_clk = ~ice_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // scoreboard monitors: compare on every rx_valid & rx_ready handshake
  always @(negedge ice_clk) begin
    if (rx_valid_a && rx_ready_a) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_rx_unexpected: got 0x%0h, expected no byte", rx_data_a);
      end else begin
        ea = q_a.pop_front();
        check("a_rx_data", 32'(rx_data_a), 32'(ea.d));
        check("a_rx_perr", 32'(pe_a), 32'(ea.pe));
        check("a_rx_ferr", 32'(fe_a), 32'(ea.fe));
      end
    end
    if (rx_overrun_a) ovr_a++;
  end

  always @(negedge ice_clk) begin
    if (rx_valid_b && rx_ready_b) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_rx_unexpected: got 0x%0h, expected no byte", rx_data_b);
      end else begin
        eb = q_b.pop_front();
        check("b_rx_data", 32'(rx_data_b), 32'(eb.d));
        check("b_rx_perr", 32'(pe_b), 32'(eb.pe));
        check("b_rx_ferr", 32'(fe_b), 32'(eb.fe));
      end
    end
    if (rx_overrun_b) ovr_b++;
  end

  always @(negedge ice_clk) begin
    if (rx_valid_c && rx_ready_c) begin
      if (q_c.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL c_rx_unexpected: got 0x%0h, expected no byte", rx_data_c);
      end else begin
        ec = q_c.pop_front();
        check("c_rx_data", 32'(rx_data_c), 32'(ec.d));
        check("c_rx_perr", 32'(pe_c), 32'(ec.pe));
        check("c_rx_ferr", 32'(fe_c), 32'(ec.fe));
      end
    end
    if (rx_overrun_c) ovr_c++;
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic wait_empty(input int which, input int bound, input string name);
    int t;
    t = 0;
    while (qsize(which) != 0 && t < bound) begin
      @(posedge ice_clk);
      t++;
    end
    repeat (2) @(posedge ice_clk);
    #1;
    if (qsize(which) != 0) timeout_fail(name);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd_a = v;
    else            rxd_c = v;
  endtask

  // drive one serial frame, starting and ending 1 time unit after a clock edge
  task automatic drive_frame(input int which, input logic [8:0] d, input int nd,
                             input int div, input bit has_par, input logic pbit,
                             input logic stopv);
    set_line(which, 1'b0);
    repeat (div) @(posedge ice_clk);
    #1;
    for (int i = 0; i < nd; i++) begin
      set_line(which, d[i]);
      repeat (div) @(posedge ice_clk);
      #1;
    end
    if (has_par) begin
      set_line(which, pbit);
      repeat (div) @(posedge ice_clk);
      #1;
    end
    set_line(which, stopv);
    repeat (div) @(posedge ice_clk);
    #1;
    set_line(which, 1'b1);
    repeat (4) @(posedge ice_clk);
    #1;
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5;
    logic       expb;
    int         k;
    bit         ok;

    a5 = 8'hA5;
    rst_a = 1; rst_bc = 1;
    rxd_a = 1; rxd_c = 1;
    cts_n_a = 0; cts_n_b = 0; cts_n_c = 0;
    tx_valid_a = 0; tx_valid_b = 0; tx_valid_c = 0;
    tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
    rx_ready_a = 1; rx_ready_b = 1; rx_ready_c = 1;

    // reset state
    repeat (3) @(posedge ice_clk);
    @(negedge ice_clk);
    check("rst_txd", 32'(txd_a), 32'h1);
    check("rst_tx_ready", 32'(tx_ready_a), 32'h0);
    check("rst_rx_valid", 32'(rx_valid_a), 32'h0);
    check("rst_rx_data", 32'(rx_data_a), 32'h0);
    check("rst_perr", 32'(pe_a), 32'h0);
    check("rst_ferr", 32'(fe_a), 32'h0);
    check("rst_overrun", 32'(rx_overrun_a), 32'h0);
    check("rst_rts_n", 32'(rts_n_a), 32'h0);
    check("rst_b_tx_ready", 32'(tx_ready_b), 32'h0);
    @(posedge ice_clk); #1;
    rst_a = 0; rst_bc = 0;
    repeat (10) @(posedge ice_clk);
    #1;

    // 8N1 0xA5: handshake in cycle 0
    tx_data_a = 8'hA5; tx_valid_a = 1;
    @(negedge ice_clk);
    check("a5_ready_c0", 32'(tx_ready_a), 32'h1);
    @(posedge ice_clk); #1;
    tx_valid_a = 0;
    for (int c = 1; c <= 1041; c++) begin
      @(negedge ice_clk);
      if (c == 1041) begin
        check("a5_txd_after", 32'(txd_a), 32'h1);
        check("a5_ready_after", 32'(tx_ready_a), 32'h1);
      end else if ((c - 1) % 104 == 0 || c % 104 == 0) begin
        k = (c - 1) / 104;
        if (k == 0)      expb = 1'b0;
        else if (k <= 8) expb = a5[k-1];
        else             expb = 1'b1;
        check($sformatf("a5_txd_c%0d", c), 32'(txd_a), 32'(expb));
      end
      if (c == 1040) check("a5_ready_busy", 32'(tx_ready_a), 32'h0);
    end

    // CTS blocks the handshake
    @(posedge ice_clk); #1;
    cts_n_a = 1;
    repeat (5) @(posedge ice_clk);
    #1;
    tx_data_a = 8'hC3; tx_valid_a = 1;
    repeat (10) begin
      @(negedge ice_clk);
      check("cts_block_ready", 32'(tx_ready_a), 32'h0);
    end
    check("cts_block_txd", 32'(txd_a), 32'h1);
    @(posedge ice_clk); #1;
    cts_n_a = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ice_clk);
      check("cts_latency_low", 32'(tx_ready_a), 32'h0);
      @(posedge ice_clk); #1;
    end
    @(negedge ice_clk);
    check("cts_latency_ready", 32'(tx_ready_a), 32'h1);
    check("cts_txd_idle", 32'(txd_a), 32'h1);
    @(posedge ice_clk); #1;
    tx_valid_a = 0;
    @(negedge ice_clk);
    check("cts_txd_start", 32'(txd_a), 32'h0);

    // reset in the middle of frame bit 3 (data bit 2 of 0xC3 = 0)
    repeat (364) @(posedge ice_clk);
    #1;
    @(negedge ice_clk);
    check("txrst_bit3_low", 32'(txd_a), 32'h0);
    @(posedge ice_clk); #1;
    rst_a = 1;
    @(negedge ice_clk);
    check("txrst_ready_in_rst", 32'(tx_ready_a), 32'h0);
    @(posedge ice_clk); #1;
    rst_a = 0;
    @(negedge ice_clk);
    check("txrst_txd_high", 32'(txd_a), 32'h1);
    repeat (208) @(posedge ice_clk);
    @(negedge ice_clk);
    check("txrst_txd_stays", 32'(txd_a), 32'h1);
    check("txrst_ready_back", 32'(tx_ready_a), 32'h1);
    @(posedge ice_clk); #1;

    // overrun: hold rx_ready low across two frames
    rx_ready_a = 0;
    q_a.push_back({9'h011, 1'b0, 1'b0});
    drive_frame(0, 9'h011, 8, 104, 1'b0, 1'b0, 1'b1);
    drive_frame(0, 9'h022, 8, 104, 1'b0, 1'b0, 1'b1);
    @(negedge ice_clk);
    check("ovr_rx_valid", 32'(rx_valid_a), 32'h1);
    check("ovr_rx_data_kept", 32'(rx_data_a), 32'h11);
    check("ovr_pulse_count", 32'(ovr_a), 32'h1);
    check("ovr_rts_n_high", 32'(rts_n_a), 32'h1);
    @(posedge ice_clk); #1;
    rx_ready_a = 1;
    @(posedge ice_clk);
    @(negedge ice_clk);
    check("ovr_rx_valid_drop", 32'(rx_valid_a), 32'h0);
    check("ovr_rts_n_low", 32'(rts_n_a), 32'h0);
    @(posedge ice_clk); #1;

    // start-bit glitch of DIV/4 cycles
    rxd_a = 0;
    repeat (26) @(posedge ice_clk);
    #1;
    rxd_a = 1;
    repeat (208) @(posedge ice_clk);
    @(negedge ice_clk);
    check("glitch_no_valid", 32'(rx_valid_a), 32'h0);
    @(posedge ice_clk); #1;

    // reset in the middle of RX frame bit 4 (line high from there on)
    fork
      drive_frame(0, 9'h0F9, 8, 104, 1'b0, 1'b0, 1'b1);
      begin
        repeat (3 + 52 + 4 * 104) @(posedge ice_clk);
        #1;
        rst_a = 1;
        @(posedge ice_clk); #1;
        rst_a = 0;
      end
    join
    repeat (208) @(posedge ice_clk);
    @(negedge ice_clk);
    check("rxrst_no_valid", 32'(rx_valid_a), 32'h0);
    @(posedge ice_clk); #1;

    // clean frame after the glitch and the reset
    q_a.push_back({9'h05A, 1'b0, 1'b0});
    drive_frame(0, 9'h05A, 8, 104, 1'b0, 1'b0, 1'b1);
    wait_empty(0, 300, "a_clean_frame");
    check("a_overrun_total", 32'(ovr_a), 32'h1);

    // loopback 0x00..0x7F back-to-back, 7E2
    tx_valid_b = 1;
    for (int v = 0; v < 128; v++) begin
      tx_data_b = 7'(v);
      q_b.push_back({9'(v), 1'b0, 1'b0});
      ok = 0;
      for (int t = 0; t < 400 && !ok; t++) begin
        @(negedge ice_clk);
        if (tx_ready_b) ok = 1;
        @(posedge ice_clk); #1;
      end
      if (!ok) begin
        timeout_fail("b_tx_ready");
        break;
      end
    end
    tx_valid_b = 0;
    wait_empty(1, 400, "b_loopback_drain");
    check("b_overrun_total", 32'(ovr_b), 32'h0);

    // odd parity: wrong parity bit, then bad stop bit, then a clean frame
    q_c.push_back({9'h03C, 1'b1, 1'b0});
    drive_frame(2, 9'h03C, 8, 16, 1'b1, 1'b0, 1'b1);
    q_c.push_back({9'h03C, 1'b0, 1'b1});
    drive_frame(2, 9'h03C, 8, 16, 1'b1, 1'b1, 1'b0);
    q_c.push_back({9'h0A7, 1'b0, 1'b0});
    drive_frame(2, 9'h0A7, 8, 16, 1'b1, 1'b0, 1'b1);
    wait_empty(2, 100, "c_drain");
    check("c_overrun_total", 32'(ovr_c), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised full-duplex UART for the iCE40 boards: one RX engine and one TX engine, with configurable data width, parity, stop bits and baud divisor. Both directions use valid/ready byte streams, and the core supports optional CTS/RTS hardware flow control. It sits between the FTDI UART pins (`uart0_*`) and the user logic, and replaces the fixed 8N1 test harness.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000, `ice_clk` frequency.
- `BAUD`, 115200, line rate. `DIV = CLK_HZ/BAUD` (integer floor). `DIV >= 8` is required; check it with a generate-time error.
- `DATA_BITS`, 8, legal values 5..9.
- `PARITY`, 0. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, legal values 1 or 2.
- `SYNC_STAGES`, 3, flop depth of the input synchronisers. Must be at least 2.
- `FLOW_CTRL`, 1. 1 = honour `cts_n` and drive `rts_n`. 0 = `cts_n` ignored and `rts_n` tied 0.

Ports:
- `ice_clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `rxd` in 1: serial input, asynchronous, idle high.
- `txd` out 1: serial output, idle high.
- `cts_n` in 1: asynchronous, active-low clear-to-send from the host.
- `rts_n` out 1: active-low request-to-send to the host.
- `tx_data` in `DATA_BITS`: byte to send.
- `tx_valid` in 1, `tx_ready` out 1: TX handshake.
- `rx_data` out `DATA_BITS`: received byte.
- `rx_valid` out 1, `rx_ready` in 1: RX handshake.
- `rx_parity_err` out 1, `rx_frame_err` out 1: sideband flags, qualified by `rx_valid`.
- `rx_overrun` out 1: one-cycle pulse.

## Operation
- Synchronisers: `rxd` and `cts_n` each pass through `SYNC_STAGES` flops. On `rst` these flops load 1 (line idle).
- Frame format: 1 start bit (0), then `DATA_BITS` data bits LSB first, then a parity bit if `PARITY != 0`, then `STOP_BITS` stop bits (1).
  - Odd parity: the XOR of data and parity is 1.
  - Even parity: the XOR of data and parity is 0.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - `tx_ready = (state == IDLE) & ~rst & (cts_sync == 0 | FLOW_CTRL == 0)`.
  - A handshake (`tx_valid & tx_ready`) latches `tx_data` into the shift register and moves to START.
  - Every state except IDLE holds `txd` for exactly `DIV` cycles per bit. The bit counter covers `DATA_BITS` bits in DATA and `STOP_BITS` bits in STOP.
  - PARITY is skipped when `PARITY == 0`.
  - `cts_n` deasserting mid-frame does not abort the frame. It only blocks the next handshake.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised high-to-low transition of `rxd` moves the FSM to START.
  - START: samples at `DIV/2` cycles. If the sample is 1 it is a glitch; return to IDLE with no output. If the sample is 0, continue.
  - Each later bit is sampled every `DIV` cycles after that, so sampling stays at mid-bit.
  - DATA shifts LSB first.
  - PARITY compares the recomputed parity with the sampled bit and stores the result.
  - STOP samples each stop bit. Any stop bit sampled 0 sets the frame error.
  - After the last stop sample the FSM returns to IDLE and can detect a new start edge on the following cycle.
  - A frame with errors is still delivered, with its error flags set.
- RX output register:
  - On frame completion with `rx_valid` = 0: load `rx_data` and both error flags, and set `rx_valid`.
  - On frame completion with `rx_valid` = 1: discard the new frame, keep the old data and flags, and pulse `rx_overrun` for 1 cycle.
  - `rx_valid & rx_ready` clears `rx_valid` on the next edge.
  - If the handshake and a frame completion land in the same cycle, the new frame loads and `rx_valid` stays 1 with no overrun.
- `rts_n` = `rx_valid` when `FLOW_CTRL == 1`, so the host is asked to pause while the byte is unconsumed.
- Reset values:
  - `txd` = 1, `tx_ready` = 0 while in reset.
  - `rx_valid` = 0, `rx_data` = 0, both error flags = 0, `rx_overrun` = 0, `rts_n` = 0.
  - Both FSMs go to IDLE and all counters go to 0.
- Reset mid-frame: `txd` returns high on the next edge and the partial RX frame is dropped silently.

## Timing
- TX: handshake in cycle 0.
  - `txd` drops to 0 in cycle 1.
  - Each bit lasts `DIV` cycles.
  - The final stop bit ends at cycle `1 + DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)`.
  - `tx_ready` is high in that cycle, if CTS allows, so back-to-back frames have no idle gap.
- TX CTS latency: a change on the `cts_n` pin affects `tx_ready` after `SYNC_STAGES` cycles.
- RX latency: `rx_valid` rises 1 cycle after the mid-bit sample of the last stop bit. Measured from the `rxd` pin falling edge this is about `SYNC_STAGES + DIV/2 + DIV*(frame_bits-1) + 1` cycles.
- `rx_overrun` is a single-cycle pulse, aligned with the cycle the discarded frame would have loaded.

## Test plan
- 8N1 at `DIV`=104, send 0xA5 with a handshake at cycle 0.
  - `txd` low over cycles 1..104, then bits 1,0,1,0,0,1,0,1 each lasting 104 cycles.
  - Stop high until cycle 1040, `tx_ready` high at cycle 1041.
- Loopback `txd`→`rxd` with `DATA_BITS`=7, `PARITY`=2, `STOP_BITS`=2: send 0x00..0x7F back-to-back. Every `rx_data` matches and all error flags are 0.
- Drive an RX frame 0x3C whose parity bit is deliberately wrong, with `PARITY`=1. Then drive 0x3C with the stop bit at 0. Required response:
  - First frame: `rx_parity_err`=1 with `rx_data`=0x3C.
  - Second frame: `rx_frame_err`=1.
- Hold `rx_ready`=0 and receive 0x11 then 0x22.
  - `rx_data` stays 0x11, `rx_overrun` pulses once and `rts_n`=1.
  - After `rx_ready`, `rx_valid` drops and `rts_n`=0.
- Pulse `rxd` low for `DIV/4` cycles: no `rx_valid`, and the FSM returns to IDLE.
  - With `cts_n`=1, `tx_valid`=1 gives `tx_ready`=0 and `txd` stays 1.
  - Dropping `cts_n` starts the frame `SYNC_STAGES`+1 cycles later.
- Assert `rst` mid-TX at bit 3 and mid-RX at bit 4.
  - `txd`=1 next cycle and `rx_valid` never rises.
  - The next clean frame is received correctly.
